pwm_bidir_multich: RTL and testbench
====================================

Name: pwm_bidir_multich

Overview:
Multi-channel successor to the single-channel bidirectional H-bridge PWM generator. It takes one signed command per channel, for example from the PID position/velocity loops. Each channel gets its own magnitude PWM and a dir1/dir2 pair; all channels share one period counter. Over the previous generation it adds:
- parametrised channel count, width, period and dead-time
- glitch-free duty updates at period boundaries only
- command saturation with a flag
- dead-time insertion on direction reversal
- per-channel brake

Parameters:
NUM_CH, 2, number of motor channels
CMD_W, 16, signed command width per channel
PERIOD, 4000, PWM period in clk cycles (100 MHz / 4000 = 25 kHz); must be < 2^(CMD_W-1)
DEAD_CYCLES, 200, cycles of dir1=dir2=0, pwm_out=0 inserted on FWD<->REV reversal; must be ≥1

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  synchronous active-low reset
enable  in  1  global output enable
cmd  in  NUM_CH*CMD_W  packed signed commands; channel i = cmd[i*CMD_W +: CMD_W]
cmd_valid  in  NUM_CH  per-channel strobe; captures cmd slice into the shadow register
brake  in  NUM_CH  per-channel brake request, level-sensitive
dir1  out  NUM_CH  H-bridge direction input 1
dir2  out  NUM_CH  H-bridge direction input 2
pwm_out  out  NUM_CH  PWM enable output
sat_flag  out  NUM_CH  1 when the last captured command was clamped
period_start  out  1  one-cycle pulse while counter==0

Behaviour:
- Reset: synchronous, evaluated only on a clk edge with reset_n=0. All outputs, counter, shadow/active registers and dead counters go to 0; all channel states go to IDLE. Reset mid-DEAD or mid-BRAKE aborts immediately.
- Counter:
  - counts 0..PERIOD-1 and wraps to 0; free-running whenever reset_n=1, regardless of enable
  - period_start is combinational (counter==0)
- Capture: on cmd_valid[i], shadow[i] <= clamp(cmd slice, -PERIOD, +PERIOD). sat_flag[i] <= 1 if clamped, else 0. The clamp is inclusive, so ±PERIOD means 100%. -2^(CMD_W-1) clamps cleanly to -PERIOD with no overflow on negation.
- Load: on the edge where counter==PERIOD-1, each channel in FWD/REV/IDLE evaluates shadow[i]:
  - mag = |shadow[i]|
  - new sign: >0 FWD, <0 REV, 0 IDLE
  - same sign or from/to IDLE: active_duty <= mag; state <= new state at that same edge
  - opposite sign (FWD<->REV): state <= DEAD, dead_cnt <= DEAD_CYCLES-1, pending_duty/pending_dir latched
  - a shadow write in the same cycle as the load edge is seen at the next boundary, not this one
- States per channel, with outputs:
  - IDLE: dir=00, pwm=0
  - FWD: dir1=1, dir2=0, pwm = PWM compare
  - REV: dir1=0, dir2=1, pwm = PWM compare
  - DEAD: dir=00, pwm=0; dead_cnt decrements each cycle; at 0 it loads pending_dir/pending_duty and enters FWD/REV mid-period without waiting for a boundary. DEAD lasts exactly DEAD_CYCLES cycles. Boundaries during DEAD do not reload; the shadow is re-evaluated at the next boundary after exit.
  - BRAKE: dir=11, pwm=1
- PWM compare: pwm_out[i] is registered. It is high in cycle t+1 iff state is FWD/REV and counter(t) < active_duty (one-cycle latency). Duty PERIOD gives constant 1; duty 0 gives constant 0.
- Brake:
  - brake[i]=1 forces BRAKE at the next edge from any state, including DEAD, cancelling the pending reversal
  - on release: BRAKE -> DEAD (DEAD_CYCLES), then the shadow is applied directly as the pending value
  - brake has priority over enable=0
- Enable: enable=0 (and brake=0) forces IDLE at the next edge with active_duty=0. Shadow and sat_flag are retained. After enable returns, the channel resumes at the next boundary. enable 0->1 with the opposite sign of the pre-disable state inserts no dead-time, because IDLE is not a direction.
- dir1/dir2 are registered outputs of the state. dir=10 and dir=01 are never adjacent cycles on one channel.

Test Plan:
1. Reset then enable=1, ch0 cmd=+1000 valid → from the next period, ch0 dir=10 and pwm_out high for exactly 1000 cycles of 4000; ch1 stays dir=00, pwm=0.
2. ch0 running +1000; mid-period write cmd=+3000 → current period keeps 1000-cycle high; next period high for 3000; no runt pulse.
3. ch0 +2000 then cmd=-500 → at the boundary dir=00, pwm=0 for exactly 200 cycles; then dir=01, pwm high until counter ≥500; 10→01 never adjacent.
4. cmd=+5000 and cmd=-32768 → clamped to +4000 (pwm constant 1) and -4000 respectively, sat_flag=1; a following cmd=+100 clears sat_flag.
5. brake[1]=1 during ch1 DEAD → next cycle dir=11, pwm=1; release → 200 cycles dir=00, then shadow direction applied.
6. reset_n=0 for one cycle mid-period with both channels active → next cycle all outputs 0, counter 0, states IDLE; enable low → outputs stay 0 while period_start keeps pulsing every 4000 cycles.

Source files
------------

// File: rtl/pwm_bidir_multich.sv
// ---------------------------------------------------------------------------
// pwm_bidir_multich
//   Multi-channel bidirectional H-bridge PWM generator. Every channel takes a
//   signed command. The command is clamped to +/-PERIOD and held in a shadow
//   register. At each period boundary the channel applies the shadow value as
//   a direction (dir1/dir2) and a magnitude duty (pwm_out). A reversal goes
//   through a dead-time window. A brake request shorts the bridge (dir=11,
//   pwm=1). One period counter is shared by all channels.
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   enable        global output enable (brake still overrides it)
//   cmd           packed signed commands, channel i = cmd[i*CMD_W +: CMD_W]
//   cmd_valid     per-channel strobe that captures a cmd slice into the shadow
//   brake         per-channel level-sensitive brake request
//   dir1, dir2    registered H-bridge direction inputs
//   pwm_out       registered PWM enable
//   sat_flag      set when the last captured command had to be clamped
//   period_start  high while the shared counter is 0
// ---------------------------------------------------------------------------
module pwm_bidir_multich #(
  parameter int NUM_CH      = 2,
  parameter int CMD_W       = 16,
  parameter int PERIOD      = 4000,
  parameter int DEAD_CYCLES = 200
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_CH*CMD_W-1:0]   cmd,
  input  logic [NUM_CH-1:0]         cmd_valid,
  input  logic [NUM_CH-1:0]         brake,
  output logic [NUM_CH-1:0]         dir1,
  output logic [NUM_CH-1:0]         dir2,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic [NUM_CH-1:0]         sat_flag,
  output logic                      period_start
);

  // The duty can reach PERIOD, so the counter and duty share a width that
  // can hold PERIOD itself.
  localparam int DW  = $clog2(PERIOD + 1);
  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic        [DW-1:0]  CNT_LAST  = DW'(PERIOD - 1);
  localparam logic        [DCW-1:0] DEAD_INIT = DCW'(DEAD_CYCLES - 1);
  // The limits are compared in CMD_W+1 bits. This keeps the negation of the
  // most negative command from overflowing.
  localparam logic signed [CMD_W:0]   LIM_HI = (CMD_W+1)'(PERIOD);
  localparam logic signed [CMD_W:0]   LIM_LO = -LIM_HI;
  localparam logic signed [CMD_W-1:0] SH_HI  = CMD_W'(PERIOD);
  localparam logic signed [CMD_W-1:0] SH_LO  = -SH_HI;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_REV,
    ST_DEAD,
    ST_BRAKE
  } state_t;

  // -------------------------------------------------------------------------
  // Shared period counter
  // -------------------------------------------------------------------------
  logic [DW-1:0] counter;
  logic          at_last;

  assign at_last      = (counter == CNT_LAST);
  assign period_start = (counter == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      counter <= '0;
    end else if (at_last) begin
      counter <= '0;
    end else begin
      counter <= counter + DW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel datapath and FSM
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                  state, state_nx;
    state_t                  pend_dir, pend_dir_nx;
    state_t                  sh_dir;
    logic signed [CMD_W-1:0] cmd_slice;
    logic signed [CMD_W:0]   cmd_ext;
    logic signed [CMD_W-1:0] clamped;
    logic                    clamp_hit;
    logic signed [CMD_W-1:0] shadow;
    logic                    sat_q;
    logic [DW-1:0]           sh_mag;
    logic [DW-1:0]           duty, duty_nx;
    logic [DW-1:0]           pend_duty, pend_duty_nx;
    logic [DCW-1:0]          dead_cnt, dead_cnt_nx;
    logic                    dir1_nx, dir2_nx, pwm_nx;
    logic                    dir1_q, dir2_q, pwm_q;
    logic                    driving, driving_nx;

    // Clamp the incoming command to the inclusive range [-PERIOD, +PERIOD].
    assign cmd_slice = cmd[i*CMD_W +: CMD_W];
    assign cmd_ext   = {cmd_slice[CMD_W-1], cmd_slice};

    always_comb begin
      clamped   = cmd_slice;
      clamp_hit = 1'b0;
      if (cmd_ext > LIM_HI) begin
        clamped   = SH_HI;
        clamp_hit = 1'b1;
      end else if (cmd_ext < LIM_LO) begin
        clamped   = SH_LO;
        clamp_hit = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        shadow <= '0;
        sat_q  <= 1'b0;
      end else if (cmd_valid[i]) begin
        shadow <= clamped;
        sat_q  <= clamp_hit;
      end
    end

    // Direction and magnitude that the shadow value requests.
    always_comb begin
      if (shadow == '0) begin
        sh_dir = ST_IDLE;
      end else if (shadow[CMD_W-1]) begin
        sh_dir = ST_REV;
      end else begin
        sh_dir = ST_FWD;
      end
      sh_mag = DW'(shadow[CMD_W-1] ? -shadow : shadow);
    end

    // State register
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state     <= ST_IDLE;
        pend_dir  <= ST_IDLE;
        duty      <= '0;
        pend_duty <= '0;
        dead_cnt  <= '0;
        dir1_q    <= 1'b0;
        dir2_q    <= 1'b0;
        pwm_q     <= 1'b0;
      end else begin
        state     <= state_nx;
        pend_dir  <= pend_dir_nx;
        duty      <= duty_nx;
        pend_duty <= pend_duty_nx;
        dead_cnt  <= dead_cnt_nx;
        dir1_q    <= dir1_nx;
        dir2_q    <= dir2_nx;
        pwm_q     <= pwm_nx;
      end
    end

    // Next state
    always_comb begin
      state_nx     = state;
      pend_dir_nx  = pend_dir;
      duty_nx      = duty;
      pend_duty_nx = pend_duty;
      dead_cnt_nx  = dead_cnt;
      if (brake[i]) begin
        state_nx = ST_BRAKE;
      end else if (!enable) begin
        state_nx = ST_IDLE;
        duty_nx  = '0;
      end else begin
        unique case (state)
          // Coming out of brake always passes through dead-time. The shadow
          // is taken directly as the pending target, so any reversal that
          // was pending before the brake is discarded.
          ST_BRAKE: begin
            state_nx     = ST_DEAD;
            dead_cnt_nx  = DEAD_INIT;
            pend_dir_nx  = sh_dir;
            pend_duty_nx = sh_mag;
          end
          ST_DEAD: begin
            if (dead_cnt == '0) begin
              state_nx = pend_dir;
              duty_nx  = pend_duty;
            end else begin
              dead_cnt_nx = dead_cnt - DCW'(1);
            end
          end
          default: begin
            if (at_last) begin
              if ((state == ST_FWD && sh_dir == ST_REV) ||
                  (state == ST_REV && sh_dir == ST_FWD)) begin
                state_nx     = ST_DEAD;
                dead_cnt_nx  = DEAD_INIT;
                pend_dir_nx  = sh_dir;
                pend_duty_nx = sh_mag;
              end else begin
                state_nx = sh_dir;
                duty_nx  = sh_mag;
              end
            end
          end
        endcase
      end
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register. The compare uses the present counter and
    // the present duty, which gives one cycle of latency. The output is also
    // gated by the next state, so it drops as soon as dead-time, idle or
    // brake is entered.
    always_comb begin
      driving    = (state == ST_FWD) || (state == ST_REV);
      driving_nx = (state_nx == ST_FWD) || (state_nx == ST_REV);
      dir1_nx    = (state_nx == ST_FWD) || (state_nx == ST_BRAKE);
      dir2_nx    = (state_nx == ST_REV) || (state_nx == ST_BRAKE);
      pwm_nx     = 1'b0;
      if (state_nx == ST_BRAKE) begin
        pwm_nx = 1'b1;
      end else if (driving_nx && driving) begin
        pwm_nx = (counter < duty);
      end
    end

    assign dir1[i]     = dir1_q;
    assign dir2[i]     = dir2_q;
    assign pwm_out[i]  = pwm_q;
    assign sat_flag[i] = sat_q;
  end

endmodule

// File: tb/tb_pwm_bidir_multich.sv
// ---------------------------------------------------------------------------
// tb_pwm_bidir_multich
//   Directed bench for pwm_bidir_multich (2 channels, CMD_W=16, PERIOD=4000,
//   DEAD_CYCLES=200). Cycle n is the n-th falling edge after reset release.
//   Up to the mid-run reset the DUT counter equals n % 4000 at that edge.
//   For every cycle, the stimulus pushes the hand-derived expected output
//   word for the next cycle. The monitor pops each entry on the falling edge
//   it belongs to and compares it with the DUT outputs.
//   Expected word: {dir1[1:0], dir2[1:0], pwm_out[1:0], sat_flag[1:0],
//   period_start}.
// ---------------------------------------------------------------------------
module tb_pwm_bidir_multich;
  localparam int P    = 4000;
  localparam int NEND = 40515;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b0;
  logic [31:0] cmd       = '0;
  logic [1:0]  cmd_valid = '0;
  logic [1:0]  brake     = '0;
  logic [1:0]  dir1, dir2, pwm_out, sat_flag;
  logic        period_start;

  pwm_bidir_multich #(
    .NUM_CH(2), .CMD_W(16), .PERIOD(P), .DEAD_CYCLES(200)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cmd(cmd),
    .cmd_valid(cmd_valid), .brake(brake), .dir1(dir1), .dir2(dir2),
    .pwm_out(pwm_out), .sat_flag(sat_flag), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     at;
    int         n;
    logic [8:0] exp;
  } item_t;

  item_t sbq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // The PWM output at cycle n reflects (counter at n-1) < duty.
  function automatic logic cmpd(input int n, input int d);
    return ((n - 1) % P) < d;
  endfunction

  // {dir1, dir2, pwm} of channel 0
  function automatic logic [2:0] exp_ch0(input int n);
    if (n < 4000)   return 3'b000;                  // idle until first boundary
    if (n == 4000)  return 3'b100;                  // FWD, pwm lags one cycle
    if (n < 8000)   return {2'b10, cmpd(n, 1000)};
    if (n < 12000)  return {2'b10, cmpd(n, 3000)};  // mid-period update applied here
    if (n < 16000)  return {2'b10, cmpd(n, 2000)};
    if (n < 16200)  return 3'b000;                  // reversal dead-time
    if (n == 16200) return 3'b010;
    if (n < 24000)  return {2'b01, cmpd(n, 500)};
    if (n < 24200)  return 3'b000;                  // reversal to clamped +4000
    if (n == 24200) return 3'b100;
    if (n <= 28000) return 3'b101;                  // full duty, 28000 still uses old duty
    if (n <= 32500) return {2'b10, cmpd(n, 100)};
    return 3'b000;                                  // reset, then disabled
  endfunction

  // {dir1, dir2, pwm} of channel 1
  function automatic logic [2:0] exp_ch1(input int n);
    if (n < 24000)  return 3'b000;
    if (n == 24000) return 3'b010;                  // IDLE->REV, no dead-time
    if (n < 28000)  return 3'b011;                  // clamped -4000, pwm constant
    if (n <= 28050) return 3'b000;                  // dead-time
    if (n <= 28100) return 3'b111;                  // brake during dead-time
    if (n <= 28300) return 3'b000;                  // 200 cycles after release
    if (n == 28301) return 3'b100;
    if (n <= 32500) return {2'b10, cmpd(n, 1500)};
    return 3'b000;
  endfunction

  function automatic logic [1:0] exp_sat(input int n);
    if (n <= 20100) return 2'b00;
    if (n <= 24300) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic exp_ps(input int n);
    if (n <= 0)     return 1'b1;
    if (n <= 32500) return (n % P) == 0;
    return ((n - 32501) % P) == 0;
  endfunction

  function automatic logic [8:0] exp_word(input int n);
    logic [2:0] e0, e1;
    e0 = exp_ch0(n);
    e1 = exp_ch1(n);
    return {e1[2], e0[2], e1[1], e0[1], e1[0], e0[0], exp_sat(n), exp_ps(n)};
  endfunction

  function automatic string phase(input int n);
    if (n <= 0)     return "reset_state";
    if (n < 8000)   return "t1_fwd1000";
    if (n < 12000)  return "t2_update3000";
    if (n < 20000)  return "t3_reversal";
    if (n < 28000)  return "t4_saturation";
    if (n <= 32500) return "t5_brake";
    return "t6_reset_disable";
  endfunction

  task automatic drive(input int n);
    cmd_valid = 2'b00;
    case (n)
      0:     begin reset_n = 1'b1; enable = 1'b1; end
      10:    begin cmd[15:0] = 16'd1000; cmd_valid = 2'b01; end
      11:    cmd = '1;                                       // junk, not strobed
      4500:  begin cmd[15:0] = 16'd3000; cmd_valid = 2'b01; end
      8100:  begin cmd[15:0] = 16'd2000; cmd_valid = 2'b01; end
      12100: begin cmd[15:0] = 16'(-500); cmd_valid = 2'b01; end
      20100: begin cmd = {16'h8000, 16'd5000}; cmd_valid = 2'b11; end
      24300: begin cmd = {16'd1500, 16'd100}; cmd_valid = 2'b11; end
      28050: brake = 2'b10;
      28100: brake = 2'b00;
      32500: reset_n = 1'b0;
      32501: begin reset_n = 1'b1; enable = 1'b0; end
      default: ;
    endcase
  endtask

  // Stimulus: drive the inputs for this cycle and push the expectation for
  // the next one.
  initial begin
    item_t it;
    for (int n = -3; n <= NEND; n++) begin
      @(negedge clk);
      drive(n);
      it.at  = longint'($time) + 10;
      it.n   = n + 1;
      it.exp = exp_word(n + 1);
      sbq.push_back(it);
    end
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor: compare every entry that is due on this falling edge.
  item_t      mon_it;
  logic [8:0] act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= longint'($time)) begin
      mon_it = sbq.pop_front();
      act = {dir1[1], dir1[0], dir2[1], dir2[0], pwm_out[1], pwm_out[0],
             sat_flag[1], sat_flag[0], period_start};
      n_cmp++;
      if (mon_it.at != longint'($time)) begin
        n_bad++;
        $display("FAIL %s n=%0d: sampled at %0d, required %0d",
                 phase(mon_it.n), mon_it.n, $time, mon_it.at);
      end else if (act !== mon_it.exp) begin
        n_bad++;
        $display("FAIL %s n=%0d: got %b, required %b (d1 d1 d2 d2 p p s s ps)",
                 phase(mon_it.n), mon_it.n, act, mon_it.exp);
      end
    end
  end

endmodule
